// File: rtl/bus_arbiter_rr_pkg.sv
// rtl/bus_arbiter_rr_pkg.sv - shared constants and helpers for the round-robin bus arbiter
// Purpose: bus-wide limits, active-low compare levels, legacy 4-master owner names
//          and the owner-index width helper used by the arbiter and its interface.
// Ports:   none (package)
package bus_arbiter_rr_pkg;

  // Upper bound on masters one arbiter instance may serve.
  localparam int BUS_ARB_MAX_MASTERS = 16;

  // Levels for active-high and active-low (req_/grnt_) signals.
  localparam logic ENABLE   = 1'b1;
  localparam logic DISABLE  = 1'b0;
  localparam logic ENABLE_  = 1'b0;
  localparam logic DISABLE_ = 1'b1;

  // Owner indices of the original fixed 4-master arbiter.
  typedef enum logic [1:0] {
    BUS_OWNER_MASTER_0 = 2'd0,
    BUS_OWNER_MASTER_1 = 2'd1,
    BUS_OWNER_MASTER_2 = 2'd2,
    BUS_OWNER_MASTER_3 = 2'd3
  } legacy_owner_e;

  // Owner index width: max(1, clog2(n)).
  function automatic int owner_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/bus_arbiter_rr_if.sv
// rtl/bus_arbiter_rr_if.sv - request/grant bundle between bus masters and the arbiter
// Purpose: groups the per-master request/grant lines and arbiter status.
// Signals: req_      per-master request, active-low
//          grnt_     per-master grant, active-low, exactly one bit low
//          owner     current owner index
//          handoff   one-cycle pulse when the owner changed
//          quota_hit one-cycle pulse when that change was forced by the hold quota
// Modports: master (bus masters side), slave (arbiter side)
interface bus_arbiter_rr_if #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2
);

  logic [NUM_MASTERS-1:0] req_;
  logic [NUM_MASTERS-1:0] grnt_;
  logic [OWNER_W-1:0]     owner;
  logic                   handoff;
  logic                   quota_hit;

  modport master (
    output req_,
    input  grnt_,
    input  owner,
    input  handoff,
    input  quota_hit
  );

  modport slave (
    input  req_,
    output grnt_,
    output owner,
    output handoff,
    output quota_hit
  );

endinterface

// File: rtl/bus_arbiter_rr_pick.sv
// rtl/bus_arbiter_rr_pick.sv - combinational first-set-bit search with wraparound
// Purpose: finds the first set bit of mask at or after start, wrapping modulo NUM_MASTERS.
// Ports:   mask  in  NUM_MASTERS  candidate mask (active-high)
//          start in  OWNER_W      first index examined, must be < NUM_MASTERS
//          found out 1            some bit of mask is set
//          index out OWNER_W      winning index (equals start when nothing is found)
module bus_arbiter_rr_pick #(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = 2
) (
  input  logic [NUM_MASTERS-1:0] mask,
  input  logic [OWNER_W-1:0]     start,
  output logic                   found,
  output logic [OWNER_W-1:0]     index
);

  logic [NUM_MASTERS-1:0] rot;
  int                     off;
  int                     sum;

  always_comb begin
    // Rotate so that bit 0 of rot is mask[start]; doubling the mask makes
    // the wrap exact for any NUM_MASTERS, not just powers of two.
    rot   = NUM_MASTERS'({mask, mask} >> start);
    found = 1'b0;
    off   = 0;
    // Descending scan so the lowest rotated offset is the one left standing.
    for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
      if (rot[i]) begin
        found = 1'b1;
        off   = i;
      end
    end
    sum = int'(start) + off;
    if (sum >= NUM_MASTERS) begin
      sum = sum - NUM_MASTERS;
    end
    index = OWNER_W'(sum);
  end

endmodule

// File: rtl/bus_arbiter_rr.sv
// rtl/bus_arbiter_rr.sv - parametrised round-robin bus arbiter with parking and hold quota
// Purpose: grants one of NUM_MASTERS masters the shared bus; priority rotates from the
//          owner, the owner parks when idle, and an optional hold quota forces a handoff.
// Ports:   clk   in  1  clock, all logic on posedge
//          reset in  1  synchronous reset, active-high
//          bus   slave  req_ in; grnt_, owner, handoff, quota_hit out (all registered
//                       or decoded from registers; no combinational req_->grnt_ path)
module bus_arbiter_rr
  import bus_arbiter_rr_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int OWNER_W     = owner_width(NUM_MASTERS),
  parameter int MAX_HOLD    = 0,
  parameter int HOLD_W      = 8
) (
  input logic            clk,
  input logic            reset,
  bus_arbiter_rr_if.slave bus
);

  logic [NUM_MASTERS-1:0] active;
  logic [NUM_MASTERS-1:0] owner_onehot;
  logic [NUM_MASTERS-1:0] pick_mask;
  logic [NUM_MASTERS-1:0] grnt_d;
  logic [OWNER_W-1:0]     owner_q;
  logic [OWNER_W-1:0]     owner_sel;
  logic [OWNER_W-1:0]     start_idx;
  logic [OWNER_W-1:0]     pick_idx;
  logic [OWNER_W-1:0]     next_owner;
  logic [HOLD_W-1:0]      hold_cnt;
  logic                   pick_found;
  logic                   owner_active;
  logic                   competing;
  logic                   force_hand;
  logic                   handoff_q;
  logic                   quota_hit_q;

  always_comb begin
    active = ~bus.req_;
    // An out-of-range owner (only possible for non power-of-two counts) is treated as 0.
    owner_sel    = (int'(owner_q) < NUM_MASTERS) ? owner_q : '0;
    owner_onehot = NUM_MASTERS'(1) << owner_sel;
    owner_active = (active[owner_sel] == ENABLE);
    competing    = |(active & ~owner_onehot);
    force_hand   = (MAX_HOLD > 0) && owner_active && competing &&
                   (hold_cnt == HOLD_W'(MAX_HOLD - 1));
    // A forced handoff must skip the still-requesting owner.
    pick_mask    = force_hand ? (active & ~owner_onehot) : active;
    start_idx    = (int'(owner_sel) == NUM_MASTERS - 1) ? '0 : owner_sel + OWNER_W'(1);
  end

  bus_arbiter_rr_pick #(
    .NUM_MASTERS (NUM_MASTERS),
    .OWNER_W     (OWNER_W)
  ) u_pick (
    .mask  (pick_mask),
    .start (start_idx),
    .found (pick_found),
    .index (pick_idx)
  );

  always_comb begin
    if (owner_active && !force_hand) begin
      next_owner = owner_sel;
    end else if (pick_found) begin
      next_owner = pick_idx;
    end else begin
      next_owner = owner_sel;  // nobody requesting: park
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      owner_q     <= '0;
      hold_cnt    <= '0;
      handoff_q   <= 1'b0;
      quota_hit_q <= 1'b0;
    end else begin
      owner_q     <= next_owner;
      handoff_q   <= (next_owner != owner_q);
      quota_hit_q <= force_hand;
      if (next_owner != owner_q || !(owner_active && competing) || MAX_HOLD == 0) begin
        hold_cnt <= '0;
      end else if (hold_cnt != HOLD_W'(MAX_HOLD)) begin
        hold_cnt <= hold_cnt + HOLD_W'(1);
      end
    end
  end

  // Grant is a pure decode of the owner register.
  always_comb begin
    grnt_d            = {NUM_MASTERS{DISABLE_}};
    grnt_d[owner_sel] = ENABLE_;
  end

  assign bus.grnt_     = grnt_d;
  assign bus.owner     = owner_q;
  assign bus.handoff   = handoff_q;
  assign bus.quota_hit = quota_hit_q;

endmodule

// File: tb/tb_bus_arbiter_rr.sv
// tb/tb_bus_arbiter_rr.sv - scoreboard bench for three arbiter configurations
module tb_bus_arbiter_rr;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  bus_arbiter_rr_if #(.NUM_MASTERS(4), .OWNER_W(2)) bus0 ();
  bus_arbiter_rr_if #(.NUM_MASTERS(4), .OWNER_W(2)) bus1 ();
  bus_arbiter_rr_if #(.NUM_MASTERS(5), .OWNER_W(3)) bus2 ();

  bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(0), .HOLD_W(8))
    u0 (.clk(clk), .reset(reset), .bus(bus0.slave));
  bus_arbiter_rr #(.NUM_MASTERS(4), .OWNER_W(2), .MAX_HOLD(4), .HOLD_W(8))
    u1 (.clk(clk), .reset(reset), .bus(bus1.slave));
  bus_arbiter_rr #(.NUM_MASTERS(5), .OWNER_W(3), .MAX_HOLD(3), .HOLD_W(4))
    u2 (.clk(clk), .reset(reset), .bus(bus2.slave));

  typedef struct packed {
    logic [3:0] owner;
    logic       ho;
    logic       qh;
  } exp_t;

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  int m_owner[3];
  int m_run[3];
  int errors = 0;
  int checks = 0;

  // Reference: owner as an integer, rotation by modular scan, quota as a count
  // of consecutive contested cycles of the current owner.
  function automatic exp_t model(input int k, input int n, input int mh,
                                 input logic [15:0] act, input bit rst);
    exp_t e;
    int   o;
    int   nxt;
    bit   own;
    bit   others;
    bit   forced;
    e = '0;
    if (rst) begin
      m_owner[k] = 0;
      m_run[k]   = 0;
      return e;
    end
    o      = m_owner[k];
    own    = act[o];
    others = 1'b0;
    for (int c = 0; c < n; c++) begin
      if (c != o && act[c]) others = 1'b1;
    end
    if (own && others) m_run[k] = m_run[k] + 1;
    else               m_run[k] = 0;
    forced = own && (mh > 0) && (m_run[k] >= mh);
    nxt    = o;
    if (!own || forced) begin
      for (int d = n - 1; d >= 1; d--) begin
        if (act[(o + d) % n]) nxt = (o + d) % n;
      end
    end
    if (nxt != o) m_run[k] = 0;
    m_owner[k] = nxt;
    e.owner = 4'(nxt);
    e.ho    = (nxt != o);
    e.qh    = forced;
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_dut(input int k, input int n, input exp_t e, input logic [15:0] g,
                           input logic [3:0] o, input logic ho, input logic qh);
    logic [15:0] eg;
    eg = ~(16'd1 << e.owner) & ((16'd1 << n) - 16'd1);
    check($sformatf("dut%0d owner", k), {28'd0, o}, {28'd0, e.owner});
    check($sformatf("dut%0d grnt_", k), {16'd0, g}, {16'd0, eg});
    check($sformatf("dut%0d handoff", k), {31'd0, ho}, {31'd0, e.ho});
    check($sformatf("dut%0d quota_hit", k), {31'd0, qh}, {31'd0, e.qh});
  endtask

  // Monitor: every registered update is compared against the oldest prediction.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q0.size() > 0) begin
        e = q0.pop_front();
        check_dut(0, 4, e, {12'd0, bus0.grnt_}, {2'd0, bus0.owner}, bus0.handoff, bus0.quota_hit);
      end
      if (q1.size() > 0) begin
        e = q1.pop_front();
        check_dut(1, 4, e, {12'd0, bus1.grnt_}, {2'd0, bus1.owner}, bus1.handoff, bus1.quota_hit);
      end
      if (q2.size() > 0) begin
        e = q2.pop_front();
        check_dut(2, 5, e, {11'd0, bus2.grnt_}, {1'd0, bus2.owner}, bus2.handoff, bus2.quota_hit);
      end
    end
  end

  task automatic push_all(input bit rst, input logic [3:0] r4, input logic [4:0] r5);
    q0.push_back(model(0, 4, 0, {12'd0, ~r4}, rst));
    q1.push_back(model(1, 4, 4, {12'd0, ~r4}, rst));
    q2.push_back(model(2, 5, 3, {11'd0, ~r5}, rst));
  endtask

  task automatic step(input bit rst, input logic [3:0] r4, input logic [4:0] r5, input int cnt);
    for (int i = 0; i < cnt; i++) begin
      @(negedge clk);
      #1;
      reset     = rst;
      bus0.req_ = r4;
      bus1.req_ = r4;
      bus2.req_ = r5;
      push_all(rst, r4, r5);
    end
  endtask

  initial begin
    logic [3:0] r4;
    logic [4:0] r5;
    bit         rst;
    reset     = 1'b1;
    bus0.req_ = 4'hF;
    bus1.req_ = 4'hF;
    bus2.req_ = 5'h1F;
    push_all(1'b1, 4'hF, 5'h1F);

    // reset, then idle parking
    step(1'b1, 4'b1111, 5'b11111, 1);
    step(1'b0, 4'b1111, 5'b11111, 10);
    // owner 0 holds while master 2 waits, then releases
    step(1'b0, 4'b1110, 5'b11110, 3);
    step(1'b0, 4'b1010, 5'b11010, 8);
    step(1'b0, 4'b1011, 5'b11011, 2);
    // reach owner 3 (owner 4 on the 5-master unit), then all request and rotate
    step(1'b0, 4'b0111, 5'b01111, 2);
    step(1'b0, 4'b0000, 5'b11101, 2);
    step(1'b0, 4'b1000, 5'b00000, 1);
    step(1'b0, 4'b1001, 5'b00000, 1);
    step(1'b0, 4'b1011, 5'b00000, 1);
    // masters 1 and 3 compete continuously
    step(1'b0, 4'b1101, 5'b10101, 2);
    step(1'b0, 4'b0101, 5'b10101, 12);
    // reset while owner 2 has accumulated hold time
    step(1'b0, 4'b1011, 5'b11011, 2);
    step(1'b0, 4'b1010, 5'b11010, 3);
    step(1'b1, 4'b1010, 5'b11010, 1);
    step(1'b0, 4'b1010, 5'b11010, 6);

    // random patterns, each held a few cycles so quotas can expire
    for (int i = 0; i < 400; i++) begin
      rst = ($urandom_range(0, 39) == 0);
      r4  = 4'($urandom);
      r5  = 5'($urandom);
      step(rst, r4, r5, $urandom_range(1, 6));
    end

    @(posedge clk);
    #5;
    check("scoreboard drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
